// File: rtl/pre_enc_hash_sequencer_if.sv
// Shared-Keccak job bus between the pre-encapsulation hash sequencer and the
// sha3 core.
//   hash_start : one-cycle job launch            (sequencer -> core)
//   hash_mode  : 0 = SHA3-256, 1 = SHA3-512      (sequencer -> core)
//   hash_sel   : core input mux select           (sequencer -> core)
//   hash_valid : one-cycle digest-ready pulse    (core -> sequencer)
//   hash_out   : digest, SHA3-256 result in low KYBER_N bits (core -> sequencer)
interface pre_enc_hash_sequencer_if #(
   parameter int KYBER_N = 256
);
   logic                   hash_start;
   logic                   hash_mode;
   logic [1:0]             hash_sel;
   logic                   hash_valid;
   logic [2*KYBER_N-1:0]   hash_out;

   modport master (
      output hash_start, hash_mode, hash_sel,
      input  hash_valid, hash_out
   );

   modport slave (
      input  hash_start, hash_mode, hash_sel,
      output hash_valid, hash_out
   );
endinterface

// File: rtl/pre_enc_hash_sequencer.sv
// Runs the Kyber pre-encapsulation/decapsulation hash jobs on one shared
// Keccak core: m = H(rand) (encaps only), h = H(ek), (K-bar, r_coin) = G(m||h).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start_i           : one-cycle sequence request, sampled only in IDLE
//   kem_enc_decap_i   : 1 = encapsulation, 0 = decapsulation
//   reuse_h_i         : reuse the cached H(ek) if it is still valid
//   r_in_i            : encaps random seed / decaps message m'
//   hash_bus          : job bus to the shared sha3 core (master side)
//   msg_o, hash_ek_o  : registered m and H(ek)
//   pre_k_o, coin_o   : registered K-bar and r_coin from G
//   busy_o            : high whenever not IDLE
//   valid_o           : one-cycle completion pulse
//   error_o           : sticky timeout flag, cleared by the next accepted start
module pre_enc_hash_sequencer #(
   parameter int KYBER_N = 256,
   parameter int TIMEOUT = 1024,
   parameter int TO_W    = 11
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 kem_enc_decap_i,
   input  logic                 reuse_h_i,
   input  logic [KYBER_N-1:0]   r_in_i,
   pre_enc_hash_sequencer_if.master hash_bus,
   output logic [KYBER_N-1:0]   msg_o,
   output logic [KYBER_N-1:0]   hash_ek_o,
   output logic [KYBER_N-1:0]   pre_k_o,
   output logic [KYBER_N-1:0]   coin_o,
   output logic                 busy_o,
   output logic                 valid_o,
   output logic                 error_o
);

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_M_REQ  = 4'd1;
   localparam logic [3:0] S_M_WAIT = 4'd2;
   localparam logic [3:0] S_H_REQ  = 4'd3;
   localparam logic [3:0] S_H_WAIT = 4'd4;
   localparam logic [3:0] S_G_REQ  = 4'd5;
   localparam logic [3:0] S_G_WAIT = 4'd6;
   localparam logic [3:0] S_DONE   = 4'd7;
   localparam logic [3:0] S_ERR    = 4'd8;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   logic [3:0]          state_q, state_d;
   logic                reuse_q, reuse_d;
   logic                err_q, err_d;
   logic                hflag_q, hflag_d;
   logic [TO_W-1:0]     cnt_q, cnt_d;
   logic [KYBER_N-1:0]  msg_q, msg_d;
   logic [KYBER_N-1:0]  hek_q, hek_d;
   logic [KYBER_N-1:0]  prek_q, prek_d;
   logic [KYBER_N-1:0]  coin_q, coin_d;

   logic                eff_reuse;
   logic                expired;

   // Reuse only counts when a stored H(ek) is known good.
   assign eff_reuse = reuse_h_i & hflag_q;
   assign expired   = (cnt_q == TO_LAST);

   always_comb begin
      state_d = state_q;
      reuse_d = reuse_q;
      err_d   = err_q;
      hflag_d = hflag_q;
      cnt_d   = cnt_q;
      msg_d   = msg_q;
      hek_d   = hek_q;
      prek_d  = prek_q;
      coin_d  = coin_q;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               reuse_d = eff_reuse;
               err_d   = 1'b0;
               if (kem_enc_decap_i) begin
                  state_d = S_M_REQ;
               end else begin
                  msg_d   = r_in_i;
                  state_d = eff_reuse ? S_G_REQ : S_H_REQ;
               end
            end
         end
         S_M_REQ: begin
            cnt_d   = '0;
            state_d = S_M_WAIT;
         end
         S_H_REQ: begin
            cnt_d   = '0;
            state_d = S_H_WAIT;
         end
         S_G_REQ: begin
            cnt_d   = '0;
            state_d = S_G_WAIT;
         end
         // A digest arriving on the expiry cycle wins over the timeout.
         S_M_WAIT: begin
            cnt_d = cnt_q + TO_W'(1);
            if (hash_bus.hash_valid) begin
               msg_d   = hash_bus.hash_out[KYBER_N-1:0];
               state_d = reuse_q ? S_G_REQ : S_H_REQ;
            end else if (expired) begin
               state_d = S_ERR;
            end
         end
         S_H_WAIT: begin
            cnt_d = cnt_q + TO_W'(1);
            if (hash_bus.hash_valid) begin
               hek_d   = hash_bus.hash_out[KYBER_N-1:0];
               hflag_d = 1'b1;
               state_d = S_G_REQ;
            end else if (expired) begin
               state_d = S_ERR;
            end
         end
         S_G_WAIT: begin
            cnt_d = cnt_q + TO_W'(1);
            if (hash_bus.hash_valid) begin
               prek_d  = hash_bus.hash_out[KYBER_N-1:0];
               coin_d  = hash_bus.hash_out[2*KYBER_N-1:KYBER_N];
               state_d = S_DONE;
            end else if (expired) begin
               state_d = S_ERR;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         S_ERR: begin
            err_d   = 1'b1;
            hflag_d = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         reuse_q <= 1'b0;
         err_q   <= 1'b0;
         hflag_q <= 1'b0;
         cnt_q   <= '0;
         msg_q   <= '0;
         hek_q   <= '0;
         prek_q  <= '0;
         coin_q  <= '0;
      end else begin
         state_q <= state_d;
         reuse_q <= reuse_d;
         err_q   <= err_d;
         hflag_q <= hflag_d;
         cnt_q   <= cnt_d;
         msg_q   <= msg_d;
         hek_q   <= hek_d;
         prek_q  <= prek_d;
         coin_q  <= coin_d;
      end
   end

   // Job controls decode straight from state so reset forces them to zero.
   always_comb begin
      hash_bus.hash_start = 1'b0;
      hash_bus.hash_mode  = 1'b0;
      hash_bus.hash_sel   = 2'd0;
      case (state_q)
         S_M_REQ:  hash_bus.hash_start = 1'b1;
         S_H_REQ: begin
            hash_bus.hash_start = 1'b1;
            hash_bus.hash_sel   = 2'd1;
         end
         S_H_WAIT: hash_bus.hash_sel = 2'd1;
         S_G_REQ: begin
            hash_bus.hash_start = 1'b1;
            hash_bus.hash_mode  = 1'b1;
            hash_bus.hash_sel   = 2'd2;
         end
         S_G_WAIT: begin
            hash_bus.hash_mode = 1'b1;
            hash_bus.hash_sel  = 2'd2;
         end
         default: ;
      endcase
   end

   assign busy_o    = (state_q != S_IDLE);
   assign valid_o   = (state_q == S_DONE);
   assign error_o   = err_q;
   assign msg_o     = msg_q;
   assign hash_ek_o = hek_q;
   assign pre_k_o   = prek_q;
   assign coin_o    = coin_q;

endmodule
